bip_data_mem: RTL and testbench
===============================

// Module: bip_data_mem
// PURPOSE
//   Data-memory responder for the accumulator CPU's datapath port. It serves
//   single-cycle write requests (wr_ram) and registered read requests (rd_ram)
//   on addr_dm, taking write data on in_data and returning read data on out_data.
//   A secondary dump port streams a memory window out over valid/ready (post-run
//   inspection / UART bridge). The CPU always has priority on the single RAM port.
// PARAMETERS
//   ADDR_W  11            address width; matches the CPU addr_dm width
//   DATA_W  16            word width
//   DEPTH   1<<ADDR_W     number of words
// PORTS
//   clk         in   1        system clock; all logic on rising edge
//   rst_n       in   1        asynchronous active-low reset
//   wr_ram      in   1        CPU write strobe
//   rd_ram      in   1        CPU read strobe
//   addr_dm     in   ADDR_W   CPU word address
//   in_data     in   DATA_W   CPU write data
//   out_data    out  DATA_W   CPU read data, registered
//   dump_start  in   1        1-cycle pulse; honoured only in IDLE
//   dump_base   in   ADDR_W   first address of the dump window
//   dump_len    in   ADDR_W+1 word count, 0..DEPTH
//   dump_valid  out  1        dump_data is valid
//   dump_ready  in   1        sink accepts the word
//   dump_data   out  DATA_W   streamed word
//   dump_busy   out  1        high whenever state != IDLE
//   dump_done   out  1        1-cycle pulse at end of dump
// BEHAVIOUR
//   Reset (async, rst_n=0): out_data=0, dump_valid=0, dump_data=0, dump_busy=0,
//     dump_done=0, FSM=IDLE, ptr=0, cnt=0. RAM contents are not cleared.
//   CPU write: wr_ram=1 at an edge -> mem[addr_dm] <= in_data.
//   CPU read: rd_ram=1 at edge N -> out_data = mem[addr_dm] after edge N
//     (latency 1). out_data holds its value when rd_ram=0.
//   wr_ram and rd_ram together: read-first (old word returned), unless DMEM_RDFWD_EN.
//   Dump FSM: IDLE -> FETCH -> SEND -> (FETCH | DONE) -> IDLE
//     IDLE : dump_start -> latch ptr=dump_base, cnt=dump_len.
//            If dump_len=0, go to DONE; otherwise go to FETCH.
//     FETCH: if (wr_ram|rd_ram), stall and stay in FETCH. Otherwise
//            dump_data <= mem[ptr], dump_valid <= 1, go to SEND.
//     SEND : dump_valid and dump_data stay stable until dump_ready=1. On the
//            handshake: dump_valid <= 0, ptr <= ptr+1 (wraps mod DEPTH),
//            cnt <= cnt-1. If the new cnt is 0, go to DONE; otherwise go to FETCH.
//     DONE : dump_done=1 for one cycle, then IDLE.
//   Throughput: at most one dump word every 2 cycles.
//   dump_start while busy: ignored, with no effect on the active dump.
//   CPU write to a word already fetched into dump_data: the snapshot value is
//     sent. CPU writes to words not yet fetched are visible to the dump.
//   dump_len = DEPTH: every word is dumped once, ptr wraps to dump_base.
//   rst_n low mid-dump: the dump aborts immediately, outputs take reset values,
//     and dump_done is not pulsed.
// CONFIGURATION
//   DMEM_RDFWD_EN defined: when wr_ram=rd_ram=1 and both target addr_dm,
//     out_data = in_data (write-first forwarding).
//   DMEM_RDFWD_EN undefined: read-first; out_data = previous mem[addr_dm].
// STRUCTURE
//   Shared package bip_mem_pkg: ADDR_W/DATA_W defaults and the dump FSM state
//     enum (IDLE, FETCH, SEND, DONE, 2-bit encoding).
//   One sub-module: bip_spram (single-port sync RAM, 1-cycle read, one write
//     port). The arbitration mux and dump FSM stay in bip_data_mem.
// TESTING
//   1. Reset, write 0xBEEF @0x005, read @0x005 -> out_data=0xBEEF one cycle
//      after rd_ram; out_data=0 during reset.
//   2. wr_ram=rd_ram=1 @0x010 (old 0x1111, new 0x2222) -> out_data=0x1111;
//      with DMEM_RDFWD_EN defined -> 0x2222.
//   3. Preload 0x7FE..0x001 with 0xA0..0xA3; dump_base=0x7FE, dump_len=4,
//      dump_ready=1 -> stream 0xA0,0xA1,0xA2,0xA3 (address wrap); one dump_done
//      pulse; dump_busy falls afterwards.
//   4. Dump with dump_ready toggled randomly, and rd_ram held high for 5 cycles
//      during FETCH -> no words lost or duplicated; dump_data stable while
//      valid && !ready.
//   5. dump_len=0 -> dump_done after 2 cycles, dump_valid never asserted.
//      dump_start pulsed mid-dump -> ignored.
//   6. Assert rst_n=0 while in SEND -> dump_valid drops asynchronously, FSM
//      goes to IDLE, no dump_done pulse. A new dump after reset works normally.

Source files
------------

// File: rtl/bip_mem_pkg.sv
// Shared definitions for the accumulator CPU data memory: default widths and
// the dump-port FSM state encoding.
package bip_mem_pkg;

    localparam int DEF_ADDR_W = 11;
    localparam int DEF_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } dump_state_e;

endpackage

// File: rtl/bip_data_mem_if.sv
// CPU data-memory port plus the valid/ready dump stream port.
// master = CPU / dump sink side, slave = bip_data_mem.
interface bip_data_mem_if #(
    parameter int ADDR_W = bip_mem_pkg::DEF_ADDR_W,
    parameter int DATA_W = bip_mem_pkg::DEF_DATA_W
);
    logic              wr_ram;
    logic              rd_ram;
    logic [ADDR_W-1:0] addr_dm;
    logic [DATA_W-1:0] in_data;
    logic [DATA_W-1:0] out_data;

    logic              dump_start;
    logic [ADDR_W-1:0] dump_base;
    logic [ADDR_W:0]   dump_len;
    logic              dump_valid;
    logic              dump_ready;
    logic [DATA_W-1:0] dump_data;
    logic              dump_busy;
    logic              dump_done;

    modport master (
        output wr_ram, rd_ram, addr_dm, in_data,
        output dump_start, dump_base, dump_len, dump_ready,
        input  out_data, dump_valid, dump_data, dump_busy, dump_done
    );

    modport slave (
        input  wr_ram, rd_ram, addr_dm, in_data,
        input  dump_start, dump_base, dump_len, dump_ready,
        output out_data, dump_valid, dump_data, dump_busy, dump_done
    );
endinterface

// File: rtl/bip_spram.sv
// Single-port synchronous RAM: one write port, read-first, 1-cycle read latency.
// No reset on the array or read register so it maps onto block RAM.
module bip_spram #(
    parameter int ADDR_W = bip_mem_pkg::DEF_ADDR_W,
    parameter int DATA_W = bip_mem_pkg::DEF_DATA_W,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        rdata <= mem[addr];
    end
endmodule

// File: rtl/bip_data_mem.sv
// CPU data memory with a low-priority dump streamer sharing the single RAM port.
// Optional macro DMEM_RDFWD_EN: write-first forwarding on simultaneous wr/rd.
module bip_data_mem #(
    parameter int ADDR_W = bip_mem_pkg::DEF_ADDR_W,
    parameter int DATA_W = bip_mem_pkg::DEF_DATA_W,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic          clk,
    input  logic          rst_n,
    bip_data_mem_if.slave bus
);
    import bip_mem_pkg::*;

    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);

    dump_state_e       state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   cnt;
    logic              dump_valid_q, dump_busy_q, dump_done_q;

    logic              cpu_acc, fetch_go;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_q;

    // The CPU owns the port whenever it strobes; the dump only reads in FETCH.
    assign cpu_acc  = bus.wr_ram | bus.rd_ram;
    assign fetch_go = (state == FETCH) && !cpu_acc;
    assign ram_addr = cpu_acc ? bus.addr_dm : ptr;

    bip_spram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (bus.wr_ram),
        .addr  (ram_addr),
        .wdata (bus.in_data),
        .rdata (ram_q)
    );

    // The RAM read register is shared, so each consumer takes ram_q only in the
    // cycle after its own read and otherwise replays its held copy.
    logic              cpu_fresh, dump_fresh;
    logic [DATA_W-1:0] out_hold, dump_hold;
    logic [DATA_W-1:0] out_data_w, dump_data_w;

`ifdef DMEM_RDFWD_EN
    logic              fwd_q;
    logic [DATA_W-1:0] fwd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_q    <= 1'b0;
            fwd_data <= '0;
        end else begin
            fwd_q    <= bus.wr_ram & bus.rd_ram;
            fwd_data <= bus.in_data;
        end
    end

    assign out_data_w = cpu_fresh ? (fwd_q ? fwd_data : ram_q) : out_hold;
`else
    assign out_data_w = cpu_fresh ? ram_q : out_hold;
`endif

    assign dump_data_w = dump_fresh ? ram_q : dump_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_fresh  <= 1'b0;
            dump_fresh <= 1'b0;
            out_hold   <= '0;
            dump_hold  <= '0;
        end else begin
            cpu_fresh  <= bus.rd_ram;
            dump_fresh <= fetch_go;
            out_hold   <= out_data_w;
            dump_hold  <= dump_data_w;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            ptr          <= '0;
            cnt          <= '0;
            dump_valid_q <= 1'b0;
            dump_busy_q  <= 1'b0;
            dump_done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    dump_done_q <= 1'b0;
                    if (bus.dump_start) begin
                        ptr         <= bus.dump_base;
                        cnt         <= bus.dump_len;
                        dump_busy_q <= 1'b1;
                        if (bus.dump_len == '0) begin
                            state       <= DONE;
                            dump_done_q <= 1'b1;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (fetch_go) begin
                        dump_valid_q <= 1'b1;
                        state        <= SEND;
                    end
                end
                SEND: begin
                    if (bus.dump_ready) begin
                        dump_valid_q <= 1'b0;
                        ptr          <= ptr + PTR_ONE;
                        cnt          <= cnt - CNT_ONE;
                        if (cnt == CNT_ONE) begin
                            state       <= DONE;
                            dump_done_q <= 1'b1;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                DONE: begin
                    dump_done_q <= 1'b0;
                    dump_busy_q <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out_data   = out_data_w;
    assign bus.dump_data  = dump_data_w;
    assign bus.dump_valid = dump_valid_q;
    assign bus.dump_busy  = dump_busy_q;
    assign bus.dump_done  = dump_done_q;
endmodule

// File: tb/tb_bip_data_mem.sv
// Directed self-checking bench for bip_data_mem: CPU read/write, collisions,
// dump streaming with wrap, backpressure, stalls, zero length and reset abort.
module tb_bip_data_mem;
    localparam int AW = 11;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bip_data_mem_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    bip_data_mem #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [DW-1:0] got[$];
    int            done_cnt;
    int            valid_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.wr_ram = 1'b1; bus.addr_dm = a; bus.in_data = d;
        tick();
        bus.wr_ram = 1'b0;
    endtask

    task automatic cpu_read_check(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        bus.rd_ram = 1'b1; bus.addr_dm = a;
        tick();
        bus.rd_ram = 1'b0;
        check(tag, 32'(bus.out_data), 32'(exp));
    endtask

    // Runs a dump and records every handshaken word, checking hold stability.
    task automatic run_dump(input logic [AW-1:0] base, input logic [AW:0] len,
                            input bit rnd_ready, input bit cpu_burst, input bit restart);
        logic          prev_stall;
        logic [DW-1:0] prev_data;
        bit            finished;
        got.delete();
        done_cnt   = 0;
        valid_cnt  = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        finished   = 1'b0;
        bus.dump_start = 1'b1; bus.dump_base = base; bus.dump_len = len;
        bus.dump_ready = 1'b1;
        tick();
        bus.dump_start = 1'b0;
        for (int i = 0; i < 300 && !finished; i++) begin
            bus.dump_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.rd_ram     = cpu_burst && (i >= 1) && (i <= 5);
            bus.addr_dm    = 11'h200;
            if (restart && i == 4) begin
                bus.dump_start = 1'b1; bus.dump_base = 11'h000; bus.dump_len = 12'd1;
            end else begin
                bus.dump_start = 1'b0;
            end
            if (prev_stall) begin
                check("hold_valid", 32'(bus.dump_valid), 32'd1);
                check("hold_data", 32'(bus.dump_data), 32'(prev_data));
            end
            if (bus.dump_valid) valid_cnt++;
            if (bus.dump_valid && bus.dump_ready) got.push_back(bus.dump_data);
            prev_stall = bus.dump_valid && !bus.dump_ready;
            prev_data  = bus.dump_data;
            if (bus.dump_done) begin
                done_cnt++;
                finished = 1'b1;
            end
            tick();
        end
        bus.rd_ram = 1'b0; bus.dump_start = 1'b0; bus.dump_ready = 1'b0;
        check("dump_timeout", 32'(finished), 32'd1);
    endtask

    initial begin
        logic [DW-1:0] exp_col;
        bit            saw_valid;
        rst_n = 1'b0;
        bus.wr_ram = 1'b0; bus.rd_ram = 1'b0; bus.addr_dm = '0; bus.in_data = '0;
        bus.dump_start = 1'b0; bus.dump_base = '0; bus.dump_len = '0; bus.dump_ready = 1'b0;
        tick(); tick();

        // Reset values
        check("rst_out_data", 32'(bus.out_data), 32'h0);
        check("rst_dump_valid", 32'(bus.dump_valid), 32'h0);
        check("rst_dump_data", 32'(bus.dump_data), 32'h0);
        check("rst_dump_busy", 32'(bus.dump_busy), 32'h0);
        check("rst_dump_done", 32'(bus.dump_done), 32'h0);
        rst_n = 1'b1;
        tick();

        // Basic write then read, and hold when rd_ram drops
        cpu_write(11'h005, 16'hBEEF);
        cpu_read_check("rd_beef", 11'h005, 16'hBEEF);
        tick();
        check("rd_hold", 32'(bus.out_data), 32'hBEEF);

        // Simultaneous write and read at one address
        cpu_write(11'h010, 16'h1111);
`ifdef DMEM_RDFWD_EN
        exp_col = 16'h2222;
`else
        exp_col = 16'h1111;
`endif
        bus.wr_ram = 1'b1; bus.rd_ram = 1'b1; bus.addr_dm = 11'h010; bus.in_data = 16'h2222;
        tick();
        bus.wr_ram = 1'b0; bus.rd_ram = 1'b0;
        check("rw_collide", 32'(bus.out_data), 32'(exp_col));
        cpu_read_check("rw_after", 11'h010, 16'h2222);

        // Dump across the top-of-memory wrap with ready held high
        cpu_write(11'h7FE, 16'h00A0);
        cpu_write(11'h7FF, 16'h00A1);
        cpu_write(11'h000, 16'h00A2);
        cpu_write(11'h001, 16'h00A3);
        run_dump(11'h7FE, 12'd4, 1'b0, 1'b0, 1'b0);
        check("wrap_count", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4 && i < got.size(); i++)
            check($sformatf("wrap_word%0d", i), 32'(got[i]), 32'h00A0 + 32'(i));
        check("wrap_done_pulses", 32'(done_cnt), 32'd1);
        tick();
        check("wrap_busy_low", 32'(bus.dump_busy), 32'd0);
        check("wrap_done_low", 32'(bus.dump_done), 32'd0);

        // Random backpressure, CPU read burst, ignored restart pulse
        for (int i = 0; i < 6; i++) cpu_write(11'h100 + 11'(i), 16'h5000 + 16'(i));
        run_dump(11'h100, 12'd6, 1'b1, 1'b1, 1'b1);
        check("bp_count", 32'(got.size()), 32'd6);
        for (int i = 0; i < 6 && i < got.size(); i++)
            check($sformatf("bp_word%0d", i), 32'(got[i]), 32'h5000 + 32'(i));
        check("bp_done_pulses", 32'(done_cnt), 32'd1);
        tick();
        check("bp_busy_low", 32'(bus.dump_busy), 32'd0);

        // Zero-length dump
        run_dump(11'h100, 12'd0, 1'b0, 1'b0, 1'b0);
        check("len0_valid_cnt", 32'(valid_cnt), 32'd0);
        check("len0_words", 32'(got.size()), 32'd0);
        check("len0_done_pulses", 32'(done_cnt), 32'd1);
        tick();
        check("len0_busy_low", 32'(bus.dump_busy), 32'd0);

        // Reset while in SEND
        bus.dump_start = 1'b1; bus.dump_base = 11'h100; bus.dump_len = 12'd3;
        bus.dump_ready = 1'b0;
        tick();
        bus.dump_start = 1'b0;
        saw_valid = 1'b0;
        for (int i = 0; i < 20 && !saw_valid; i++) begin
            if (bus.dump_valid) saw_valid = 1'b1;
            else tick();
        end
        check("abort_reach_send", 32'(saw_valid), 32'd1);
        check("abort_data_pre", 32'(bus.dump_data), 32'h5000);
        #2 rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(bus.dump_valid), 32'd0);
        check("abort_busy", 32'(bus.dump_busy), 32'd0);
        check("abort_data", 32'(bus.dump_data), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.dump_done) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);
        rst_n = 1'b1;
        tick();

        // Fresh dump after the abort
        run_dump(11'h102, 12'd2, 1'b0, 1'b0, 1'b0);
        check("post_count", 32'(got.size()), 32'd2);
        for (int i = 0; i < 2 && i < got.size(); i++)
            check($sformatf("post_word%0d", i), 32'(got[i]), 32'h5002 + 32'(i));
        check("post_done_pulses", 32'(done_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
